// File: rtl/block_plotter.sv
// Block plotter: queues block-draw requests and streams BLOCK x BLOCK pixels
// per request to a vga_adapter, clipping anything outside the 160x120 screen.
module block_plotter #(
  parameter int FIFO_DEPTH = 4,
  parameter int BLOCK      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       req_valid,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  output logic       req_ready,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int NPIX = BLOCK * BLOCK;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int LB   = $clog2(BLOCK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } req_t;

  state_t        state, state_next;
  req_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  logic [7:0]    bx;
  logic [6:0]    by;
  logic [2:0]    bc;
  logic [PW-1:0] p;
  logic [PW-1:0] col, row;
  logic [8:0]    x_sum;
  logic [7:0]    y_sum;
  logic          clip;

  // clear wins over both queue operations on the same edge.
  assign req_ready = (count < CW'(FIFO_DEPTH));
  assign push      = req_valid && req_ready && !clear;
  assign pop       = (state == IDLE) && (count != '0) && !clear;

  // NOTE: storage has no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{x: req_x, y: req_y, c: req_colour};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (count != '0) state_next = PLOT;
        PLOT:    if (p == PW'(NPIX - 1)) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bx <= '0;
      by <= '0;
      bc <= '0;
      p  <= '0;
    end else if (clear) begin
      p  <= '0;
    end else if (pop) begin
      bx <= mem[rd_ptr].x;
      by <= mem[rd_ptr].y;
      bc <= mem[rd_ptr].c;
      p  <= '0;
    end else if (state == PLOT) begin
      p  <= p + 1'b1;
    end
  end

  // One extra bit keeps the carry so wrapped coordinates are clipped too.
  assign col   = p & PW'(BLOCK - 1);
  assign row   = p >> LB;
  assign x_sum = {1'b0, bx} + 9'(col);
  assign y_sum = {1'b0, by} + 8'(row);
  assign clip  = (x_sum > 9'd159) || (y_sum > 8'd119);

  always_comb begin
    x_out      = '0;
    y_out      = '0;
    colour_out = '0;
    plot       = 1'b0;
    if (state == PLOT) begin
      x_out      = x_sum[7:0];
      y_out      = y_sum[6:0];
      colour_out = bc;
      plot       = !clip;
    end
  end

  assign busy = (state != IDLE) || (count != '0);
  assign done = (state == DONE);

endmodule

// File: tb/tb_block_plotter.sv
// Scoreboard bench for block_plotter: expected pixels/done pulses are queued
// at request acceptance and matched against DUT output at each falling edge.
module tb_block_plotter;

  localparam int BLK = 4;

  logic       clk = 1'b0;
  logic       reset, clear, req_valid;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [2:0] req_colour;
  logic       req_ready, plot, busy, done;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;

  block_plotter #(.FIFO_DEPTH(4), .BLOCK(BLK)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .req_ready(req_ready), .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_bounds(int x, int y, int p);
    return ((x + p % BLK) <= 159) && ((y + p / BLK) <= 119);
  endfunction

  function automatic void add_block(int x, int y, int c);
    for (int p = 0; p < BLK * BLK; p++)
      if (in_bounds(x, y, p)) sb.push_back('{0, x + p % BLK, y + p / BLK, c});
    sb.push_back('{1, 0, 0, 0});
  endfunction

  // Monitor: every plot or done cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (plot || done) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {30'd0, plot, done}, 0);
      end else begin
        e = sb.pop_front();
        if (e.is_done) begin
          check("done_order", {30'd0, plot, done}, 2'b01);
        end else begin
          check("pix_flags", {30'd0, plot, done}, 2'b10);
          check("pix_x", x_out, e.x);
          check("pix_y", y_out, e.y);
          check("pix_c", colour_out, e.c);
        end
      end
    end
  end

  // Drive one request and hold it until accepted; returns #1 after the accepting edge.
  task automatic push(input int x, input int y, input int c);
    int budget = 300;
    req_x = 8'(x); req_y = 7'(y); req_colour = 3'(c); req_valid = 1'b1;
    while (!req_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!req_ready) begin
      check("push_timeout", req_ready, 1);
    end else begin
      @(posedge clk); #1;
      add_block(x, y, c);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 500;
    while (busy && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("idle_timeout", busy, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("sb_drained", sb.size(), 0);
  endtask

  // Single block from an idle, empty DUT with cycle-exact plot/done/busy checks.
  task automatic timed_block(input int x, input int y, input int c);
    push(x, y, c);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      check("t_plot", plot, (k <= 16) && in_bounds(x, y, k - 1));
      check("t_done", done, k == 17);
      check("t_busy", busy, k <= 17);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; req_valid = 1'b0;
    req_x = '0; req_y = '0; req_colour = '0;
    #1;
    check("rst_plot", plot, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_xyc", {x_out, y_out, colour_out}, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_xyc", {x_out, y_out, colour_out}, 0);

    // Basic block, then clipping at the screen corner and with x carry-out.
    timed_block(80, 60, 3'b010);
    check("after_busy", busy, 0);
    timed_block(158, 118, 3'b101);
    timed_block(254, 10, 3'b111);
    timed_block(0, 0, 3'b001);
    wait_idle();

    // Back-to-back pushes: the second coincides with the first pop, so the
    // queue fills after the fifth accept; the sixth waits for a pop.
    push(10, 20, 1);
    push(30, 40, 2);
    push(50, 60, 3);
    push(70, 80, 4);
    push(90, 100, 5);
    check("full_ready", req_ready, 0);
    check("full_busy", busy, 1);
    push(150, 116, 6);
    wait_idle();

    // clear during p=7 of a block with two requests queued, plus a push
    // offered on the clear edge which must be dropped.
    push(4, 8, 2);
    push(12, 16, 3);
    push(20, 24, 4);
    repeat (6) begin @(posedge clk); #1; end
    clear = 1'b1;
    req_x = 8'd100; req_y = 7'd50; req_colour = 3'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; req_valid = 1'b0;
    sb.delete();
    check("clr_plot", plot, 0);
    check("clr_done", done, 0);
    check("clr_busy", busy, 0);
    check("clr_ready", req_ready, 1);
    repeat (25) begin @(posedge clk); #1; end
    check("clr_quiet_busy", busy, 0);

    // Asynchronous reset between edges in the middle of a block.
    push(20, 30, 5);
    push(40, 30, 6);
    repeat (5) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    sb.delete();
    #1;
    check("arst_plot", plot, 0);
    check("arst_done", done, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", req_ready, 1);
    check("arst_xyc", {x_out, y_out, colour_out}, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (25) begin @(posedge clk); #1; end
    check("arst_quiet_busy", busy, 0);

    // Fresh request after reset draws normally.
    timed_block(100, 100, 3'b011);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
